round_sequencer: RTL and testbench
==================================

# round_sequencer

Sequences one TypeRacer round once the player has chosen a mode and target on the select screen. It latches mode and target on `start`, runs a 3-2-1 countdown, then runs the round. In time mode it counts down seconds; in word mode it counts down completed words. It raises `finish` when the target is exhausted and holds per-round statistics (elapsed seconds, words, errors) for the result screen.

## Interface
- `TICKS_PER_SEC`, default 100_000_000: `clk` cycles per game second. The bench uses 4.
- `CD_SECS`, default 3: countdown length in seconds, range 1..3.
- `clk` in 1: system clock.
- `rst` in 1: reset, asynchronous and active-low.
- `start` in 1: one-cycle pulse (centre button, already debounced).
- `abort` in 1: one-cycle pulse that cancels the round.
- `mode` in 1: 0 = time mode, 1 = word mode. Sampled only when `start` is accepted.
- `value` in 7: target seconds (time mode) or target words (word mode). Sampled with `mode`.
- `word_done` in 1: one-cycle pulse for each correctly completed word.
- `key_err` in 1: one-cycle pulse for each wrong keystroke.
- `state` out 2: IDLE=0, COUNTDOWN=1, RUN=2, DONE=3.
- `countdown` out 2: seconds left in the countdown. 0 outside COUNTDOWN.
- `remaining` out 7: seconds or words left.
- `elapsed` out 8: seconds spent in RUN.
- `words` out 7: completed words.
- `errors` out 8: wrong keystrokes.
- `finish` out 1: one-cycle pulse when the round completes.

## Operation
- **Reset:** all outputs are 0, `state`=IDLE, prescaler=0, latched mode=0.
- **Prescaler:**
  - Counts 0..TICKS_PER_SEC-1 and wraps.
  - `sec_tick` = (count == TICKS_PER_SEC-1) while in COUNTDOWN or RUN.
  - Count is held at 0 in IDLE and DONE.
  - Count clears on the IDLE→COUNTDOWN and COUNTDOWN→RUN transitions.
- **IDLE, on `start`:**
  - Latch `mode`. Load `remaining` = `value`; a `value` of 0 is loaded as 1.
  - Clear `elapsed`, `words` and `errors`.
  - Set `countdown` = CD_SECS and go to COUNTDOWN.
- **COUNTDOWN:**
  - Each `sec_tick` decrements `countdown`.
  - A tick while `countdown`==1 sets `countdown` to 0 and goes to RUN.
  - `word_done` and `key_err` are ignored.
- **RUN, both modes:**
  - `sec_tick` increments `elapsed`, saturating at 255.
  - `word_done` increments `words`, saturating at 127.
  - `key_err` increments `errors`, saturating at 255.
- **RUN, time mode:** `sec_tick` decrements `remaining`. A tick while `remaining`==1 goes to DONE.
- **RUN, word mode:** `word_done` decrements `remaining`. A `word_done` while `remaining`==1 goes to DONE.
- **DONE:**
  - All counters hold.
  - `start` returns to IDLE and the statistics are kept.
  - The next `start` in IDLE clears them.
- **`abort`:** in COUNTDOWN or RUN, goes to IDLE. `finish` stays low, `remaining` and `countdown` clear, statistics hold. In IDLE and DONE it is ignored.
- **Ignored inputs:** `start` is ignored in COUNTDOWN and RUN.
- **Simultaneous events:**
  - `abort` beats completion.
  - All counter updates in the completing cycle still take effect, e.g. the last `word_done` together with a `sec_tick` updates both `words` and `elapsed`.
  - `start` and `abort` together in IDLE: `start` wins.
  - `word_done` and `key_err` together: both counters update.

## Timing
- All outputs are registered. There are no combinational input→output paths.
- `start` at edge N: `state`=COUNTDOWN and `countdown`=CD_SECS are visible after edge N.
- RUN is entered exactly CD_SECS×TICKS_PER_SEC cycles after COUNTDOWN is entered.
- Time mode: DONE follows exactly `value`×TICKS_PER_SEC cycles of RUN.
- `finish` is high during exactly the first cycle in which `state`=DONE, then low.
- Asynchronous reset mid-round forces all reset values immediately. No `finish` pulse is produced.

## Structure
- Shared package `typer_pkg` holds:
  - state constants SELECT/IDLE=0, COUNTDOWN=1, RUN=2, DONE=3;
  - mode constants MODE_TIME=0, MODE_WORD=1;
  - widths VALUE_W=7, STAT_W=8.
- One natural sub-module, `sec_prescaler`:
  - parameter TICKS_PER_SEC;
  - ports `clk`, `rst`, `en`, `clr`, `tick`.
- The FSM, target/statistics counters and `finish` register stay in `round_sequencer`.

## Test plan
All scenarios use TICKS_PER_SEC=4 and CD_SECS=3.
- **Time-mode round:** `mode`=0, `value`=15, `start` → `countdown` reads 3,2,1 at 4-cycle spacing. RUN begins 12 cycles after COUNTDOWN. `remaining` goes 15→0 over 60 cycles. One `finish` pulse. `elapsed`=15.
- **Word-mode round:** `mode`=1, `value`=25, then 25 `word_done` pulses with 3 `key_err` pulses interleaved → DONE on the 25th word, `words`=25, `errors`=3, `finish` pulses once.
- **Zero target and ignored events:** `value`=0 in time mode → RUN lasts 4 cycles. `word_done` pulses during COUNTDOWN leave `words`=0.
- **Abort:** `abort` at RUN `elapsed`=5 → IDLE, `finish` never asserts, `elapsed` holds 5. A later `start` clears the statistics.
- **Simultaneous completion:** in word mode, the last `word_done` coincides with `sec_tick` → DONE, `elapsed` incremented, `words`=target. `abort` in that same cycle → IDLE and no `finish`.
- **Reset mid-round:** assert `rst`=0 in COUNTDOWN → immediately IDLE with all outputs 0. `start` and `abort` in DONE behave as specified.

Source files
------------

// File: rtl/typer_pkg.sv
// Shared types, widths and helpers for the typing-game round logic.
package typer_pkg;

  localparam int unsigned VALUE_W = 7;
  localparam int unsigned STAT_W  = 8;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_COUNTDOWN = 2'd1,
    ST_RUN       = 2'd2,
    ST_DONE      = 2'd3
  } state_t;

  // The select screen and idle are the same state.
  localparam state_t ST_SELECT = ST_IDLE;

  localparam logic MODE_TIME = 1'b0;
  localparam logic MODE_WORD = 1'b1;

  // Increment that sticks at all-ones.
  function automatic logic [STAT_W-1:0] sat_inc(input logic [STAT_W-1:0] v);
    return (v == '1) ? v : v + STAT_W'(1);
  endfunction

endpackage

// File: rtl/round_sequencer_sec_prescaler.sv
// Game-second prescaler: divides clk down to a one-cycle sec tick.
module sec_prescaler #(
  parameter int unsigned TICKS_PER_SEC = 100_000_000
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic clr,
  output logic tick
);

  localparam int unsigned CNT_W = (TICKS_PER_SEC > 1) ? $clog2(TICKS_PER_SEC) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(TICKS_PER_SEC - 1);

  logic [CNT_W-1:0] cnt_q;

  // Free-running while enabled, parked at zero otherwise or on clear.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q <= '0;
    end else if (clr || !en || (cnt_q == LAST)) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_q + CNT_W'(1);
    end
  end

  assign tick = en && (cnt_q == LAST);

endmodule

// File: rtl/round_sequencer.sv
// Round sequencer: countdown, timed or word-counted run, and round stats.
module round_sequencer
  import typer_pkg::*;
#(
  parameter int unsigned TICKS_PER_SEC = 100_000_000,
  parameter int unsigned CD_SECS       = 3
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               abort,
  input  logic               mode,
  input  logic [VALUE_W-1:0] value,
  input  logic               word_done,
  input  logic               key_err,
  output logic [1:0]         state,
  output logic [1:0]         countdown,
  output logic [VALUE_W-1:0] remaining,
  output logic [STAT_W-1:0]  elapsed,
  output logic [VALUE_W-1:0] words,
  output logic [STAT_W-1:0]  errors,
  output logic               finish
);

  state_t             state_q, state_d;
  logic [1:0]         cd_q, cd_d;
  logic [VALUE_W-1:0] rem_q, rem_d;
  logic [STAT_W-1:0]  el_q, el_d;
  logic [VALUE_W-1:0] wd_q, wd_d;
  logic [STAT_W-1:0]  er_q, er_d;
  logic               mode_q, mode_d;
  logic               fin_q, fin_d;
  logic               clr_c, en_c, tick_c;

  assign en_c = (state_q == ST_COUNTDOWN) || (state_q == ST_RUN);

  sec_prescaler #(.TICKS_PER_SEC(TICKS_PER_SEC)) u_presc (
    .clk  (clk),
    .rst  (rst),
    .en   (en_c),
    .clr  (clr_c),
    .tick (tick_c)
  );

  // State and counter registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_SELECT;
      cd_q    <= '0;
      rem_q   <= '0;
      el_q    <= '0;
      wd_q    <= '0;
      er_q    <= '0;
      mode_q  <= MODE_TIME;
      fin_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cd_q    <= cd_d;
      rem_q   <= rem_d;
      el_q    <= el_d;
      wd_q    <= wd_d;
      er_q    <= er_d;
      mode_q  <= mode_d;
      fin_q   <= fin_d;
    end
  end

  // Next-state and counter update logic; abort takes priority over completion.
  always_comb begin
    state_d = state_q;
    cd_d    = cd_q;
    rem_d   = rem_q;
    el_d    = el_q;
    wd_d    = wd_q;
    er_d    = er_q;
    mode_d  = mode_q;
    fin_d   = 1'b0;
    clr_c   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          mode_d  = mode;
          rem_d   = (value == '0) ? VALUE_W'(1) : value;
          el_d    = '0;
          wd_d    = '0;
          er_d    = '0;
          cd_d    = 2'(CD_SECS);
          clr_c   = 1'b1;
          state_d = ST_COUNTDOWN;
        end
      end
      ST_COUNTDOWN: begin
        if (abort) begin
          state_d = ST_IDLE;
          rem_d   = '0;
          cd_d    = '0;
        end else if (tick_c) begin
          cd_d = cd_q - 2'(1);
          if (cd_q == 2'(1)) begin
            clr_c   = 1'b1;
            state_d = ST_RUN;
          end
        end
      end
      ST_RUN: begin
        if (abort) begin
          state_d = ST_IDLE;
          rem_d   = '0;
        end else begin
          if (tick_c) el_d = sat_inc(el_q);
          if (key_err) er_d = sat_inc(er_q);
          if (word_done && (wd_q != '1)) wd_d = wd_q + VALUE_W'(1);
          if (mode_q == MODE_WORD) begin
            if (word_done) begin
              rem_d = rem_q - VALUE_W'(1);
              if (rem_q == VALUE_W'(1)) begin
                state_d = ST_DONE;
                fin_d   = 1'b1;
              end
            end
          end else if (tick_c) begin
            rem_d = rem_q - VALUE_W'(1);
            if (rem_q == VALUE_W'(1)) begin
              state_d = ST_DONE;
              fin_d   = 1'b1;
            end
          end
        end
      end
      ST_DONE: begin
        if (start) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign state     = state_q;
  assign countdown = cd_q;
  assign remaining = rem_q;
  assign elapsed   = el_q;
  assign words     = wd_q;
  assign errors    = er_q;
  assign finish    = fin_q;

endmodule

// File: tb/tb_round_sequencer.sv
// Bench for round_sequencer: time-based reference model plus directed scenarios.
module tb_round_sequencer;

  localparam int unsigned T  = 4;
  localparam int unsigned CD = 3;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       start = 1'b0, abort = 1'b0, mode = 1'b0;
  logic       word_done = 1'b0, key_err = 1'b0;
  logic [6:0] value = '0;
  logic [1:0] state, countdown;
  logic [6:0] remaining, words;
  logic [7:0] elapsed, errors;
  logic       finish;

  round_sequencer #(.TICKS_PER_SEC(T), .CD_SECS(CD)) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort), .mode(mode),
    .value(value), .word_done(word_done), .key_err(key_err),
    .state(state), .countdown(countdown), .remaining(remaining),
    .elapsed(elapsed), .words(words), .errors(errors), .finish(finish)
  );

  always #5 clk = ~clk;

  int tests = 0, fails = 0, fin_cnt = 0;
  bit cmp_en = 1'b0;

  task automatic chk(input string name, input int act, input int exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: derives outputs from elapsed cycle counts in each phase.
  int m_st, m_phase, m_target, m_cd, m_rem, m_el, m_words, m_errs;
  bit m_mode, m_fin;

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_st = 0; m_phase = 0; m_target = 0; m_cd = 0; m_rem = 0;
      m_el = 0; m_words = 0; m_errs = 0; m_mode = 0; m_fin = 0;
    end else begin
      m_fin = 0;
      case (m_st)
        0: if (start) begin
          m_mode = mode;
          m_target = (value == 0) ? 1 : int'(value);
          m_rem = m_target; m_el = 0; m_words = 0; m_errs = 0;
          m_phase = 0; m_cd = CD; m_st = 1;
        end
        1: begin
          if (abort) begin
            m_st = 0; m_rem = 0; m_cd = 0;
          end else begin
            m_phase++;
            if (m_phase == CD * T) begin
              m_st = 2; m_phase = 0; m_cd = 0;
            end else begin
              m_cd = CD - m_phase / T;
            end
          end
        end
        2: begin
          if (abort) begin
            m_st = 0; m_rem = 0;
          end else begin
            m_phase++;
            m_el = (m_phase / T > 255) ? 255 : m_phase / T;
            if (word_done && m_words < 127) m_words++;
            if (key_err && m_errs < 255) m_errs++;
            if (!m_mode) begin
              m_rem = m_target - m_phase / T;
              if (m_phase == m_target * T) begin m_st = 3; m_fin = 1; end
            end else begin
              m_rem = m_target - m_words;
              if (word_done && m_rem == 0) begin m_st = 3; m_fin = 1; end
            end
          end
        end
        default: if (start) m_st = 0;
      endcase
    end
  end

  // Per-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (rst && cmp_en) begin
      chk("state", int'(state), m_st);
      chk("countdown", int'(countdown), m_cd);
      chk("remaining", int'(remaining), m_rem);
      chk("elapsed", int'(elapsed), m_el);
      chk("words", int'(words), m_words);
      chk("errors", int'(errors), m_errs);
      chk("finish", int'(finish), int'(m_fin));
      if (finish) fin_cnt++;
    end
  end

  // Drive one cycle of inputs; returns just after the sampling edge.
  task automatic cyc(input logic s, input logic a, input logic wd, input logic ke);
    start = s; abort = a; word_done = wd; key_err = ke;
    @(posedge clk); #1;
    start = 0; abort = 0; word_done = 0; key_err = 0;
  endtask

  task automatic launch(input logic m, input int v);
    mode = m; value = 7'(v);
    cyc(1, 0, 0, 0);
  endtask

  task automatic wait_state(input int st, input int budget, output int n);
    n = 0;
    while (int'(state) != st && n < budget) begin
      @(posedge clk); #1;
      n++;
    end
    chk($sformatf("reach_state_%0d", st), int'(state), st);
  endtask

  int n, f0;

  initial begin
    repeat (2) @(posedge clk);
    #1;
    chk("rst_state", int'(state), 0);
    chk("rst_countdown", int'(countdown), 0);
    chk("rst_remaining", int'(remaining), 0);
    chk("rst_elapsed", int'(elapsed), 0);
    chk("rst_words", int'(words), 0);
    chk("rst_errors", int'(errors), 0);
    chk("rst_finish", int'(finish), 0);
    rst = 1; cmp_en = 1;

    // Time-mode round, 15 seconds.
    launch(0, 15);
    chk("tm_state_cd", int'(state), 1);
    chk("tm_cd3", int'(countdown), 3);
    repeat (4) cyc(0, 0, 0, 0);
    chk("tm_cd2", int'(countdown), 2);
    repeat (4) cyc(0, 0, 0, 0);
    chk("tm_cd1", int'(countdown), 1);
    wait_state(2, 20, n);
    chk("tm_run_latency", 8 + n, 12);
    chk("tm_rem_start", int'(remaining), 15);
    f0 = fin_cnt;
    wait_state(3, 100, n);
    chk("tm_run_len", n, 60);
    chk("tm_elapsed", int'(elapsed), 15);
    chk("tm_rem_end", int'(remaining), 0);
    cyc(0, 0, 0, 0);
    chk("tm_finish_cnt", fin_cnt - f0, 1);
    chk("tm_finish_low", int'(finish), 0);
    cyc(1, 0, 0, 0);
    chk("tm_back_idle", int'(state), 0);
    chk("tm_stats_kept", int'(elapsed), 15);

    // Word-mode round, 25 words, 3 errors (one coincident with a word).
    launch(1, 25);
    wait_state(2, 20, n);
    f0 = fin_cnt;
    for (int i = 0; i < 25; i++) begin
      cyc(0, 0, 1, i == 10);
      cyc(0, 0, 0, i == 3 || i == 17);
    end
    chk("wm_state", int'(state), 3);
    chk("wm_words", int'(words), 25);
    chk("wm_errors", int'(errors), 3);
    chk("wm_finish_cnt", fin_cnt - f0, 1);
    cyc(1, 0, 0, 0);

    // Zero target and ignored countdown events.
    launch(0, 0);
    chk("zt_rem", int'(remaining), 1);
    cyc(0, 0, 1, 0);
    cyc(0, 0, 1, 1);
    wait_state(2, 20, n);
    wait_state(3, 20, n);
    chk("zt_run_len", n, 4);
    chk("zt_words", int'(words), 0);
    chk("zt_errors", int'(errors), 0);
    cyc(1, 0, 0, 0);

    // Abort during RUN at elapsed 5.
    launch(0, 20);
    wait_state(2, 20, n);
    n = 0;
    while (elapsed != 8'd5 && n < 100) begin cyc(0, 0, 0, 0); n++; end
    chk("ab_elapsed5", int'(elapsed), 5);
    f0 = fin_cnt;
    cyc(0, 1, 0, 0);
    chk("ab_state", int'(state), 0);
    chk("ab_rem", int'(remaining), 0);
    repeat (8) cyc(0, 0, 0, 0);
    chk("ab_no_finish", fin_cnt - f0, 0);
    chk("ab_elapsed_hold", int'(elapsed), 5);
    cyc(0, 1, 0, 0);
    chk("ab_idle_ignored", int'(state), 0);
    launch(0, 3);
    chk("ab_restart_elapsed", int'(elapsed), 0);
    cyc(0, 1, 0, 0);
    chk("ab_cd_state", int'(state), 0);
    chk("ab_cd_countdown", int'(countdown), 0);

    // Last word coincides with a second tick.
    launch(1, 2);
    wait_state(2, 20, n);
    f0 = fin_cnt;
    cyc(0, 0, 1, 0);
    cyc(0, 0, 0, 0);
    cyc(0, 0, 0, 0);
    cyc(0, 0, 1, 0);
    chk("sim_state", int'(state), 3);
    chk("sim_elapsed", int'(elapsed), 1);
    chk("sim_words", int'(words), 2);
    cyc(0, 0, 0, 0);
    chk("sim_finish_cnt", fin_cnt - f0, 1);
    cyc(0, 1, 0, 0);
    chk("done_abort_ignored", int'(state), 3);
    cyc(1, 0, 0, 0);
    chk("done_start_idle", int'(state), 0);
    chk("done_stats_kept", int'(words), 2);

    // Same, but abort arrives with the completing word.
    launch(1, 2);
    wait_state(2, 20, n);
    f0 = fin_cnt;
    cyc(0, 0, 1, 0);
    cyc(0, 0, 0, 0);
    cyc(0, 0, 0, 0);
    cyc(0, 1, 1, 0);
    chk("simab_state", int'(state), 0);
    chk("simab_words", int'(words), 1);
    cyc(0, 0, 0, 0);
    chk("simab_no_finish", fin_cnt - f0, 0);

    // Start and abort together in IDLE: start wins.
    mode = 0; value = 7'd2;
    cyc(1, 1, 0, 0);
    chk("sa_state", int'(state), 1);
    chk("sa_countdown", int'(countdown), 3);

    // Asynchronous reset mid-countdown.
    cyc(0, 0, 0, 0);
    cyc(0, 0, 0, 0);
    #2 rst = 0;
    #1;
    chk("ar_state", int'(state), 0);
    chk("ar_countdown", int'(countdown), 0);
    chk("ar_remaining", int'(remaining), 0);
    chk("ar_elapsed", int'(elapsed), 0);
    chk("ar_words", int'(words), 0);
    chk("ar_errors", int'(errors), 0);
    chk("ar_finish", int'(finish), 0);
    @(posedge clk); #1;
    rst = 1;
    repeat (3) cyc(0, 0, 0, 0);
    chk("ar_after_state", int'(state), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
